// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller.
//   ALU_W / ALU_OPW     : default operand/result and opcode widths
//   ALU_SETTLE          : default clock edges between driving alu_* and sampling alu_x/alu_y
//   ALU_DEPTH           : default command FIFO depth
//   alu_state_e         : issue FSM state (IDLE -> DRIVE -> RESP)
//   alu_cmd_t           : one command {a, b, op} at the default widths
package alu_pkg;

  localparam int ALU_W      = 4;
  localparam int ALU_OPW    = 4;
  localparam int ALU_SETTLE = 2;
  localparam int ALU_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic [ALU_W-1:0]   a;
    logic [ALU_W-1:0]   b;
    logic [ALU_OPW-1:0] op;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous show-ahead FIFO holding buffered ALU commands.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   push_i        : write push_data_i this edge (ignored when full)
//   push_data_i   : command word {a, b, op}
//   pop_i         : drop the head entry this edge (ignored when empty)
//   head_o        : current head entry, valid whenever empty_o is low
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
// Push and pop on the same edge both take effect; the count stays unchanged.
module alu_cmd_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; entries are only observable after a push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU operand interface.
// Commands {a, b, op} arrive on a valid/ready stream, are buffered in a FIFO and
// issued one at a time onto registered alu_a/alu_b/alu_opcode. SETTLE edges later
// alu_x/alu_y are captured and returned on a valid/ready response stream in
// command order. The opcode is carried through untouched.
// Ports:
//   clk, rst_n                     : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready            : command stream, cmd_a/cmd_b/cmd_op payload
//   alu_a/alu_b/alu_opcode         : registered operands to the combinational ALU
//   alu_x/alu_y                    : ALU results
//   rsp_valid/rsp_ready            : response stream, rsp_x/rsp_y/rsp_op payload
//   busy                           : FSM not idle or commands still buffered
//   tx_count                       : completed responses, modulo 256
//   dbg_state                      : current FSM state
// Handshake rule (both streams): a transfer happens on a rising edge where valid
// and ready are both high; the source keeps valid and payload stable until then,
// and ready never depends on valid.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W      = ALU_W,
  parameter int OPW    = ALU_OPW,
  parameter int SETTLE = ALU_SETTLE,
  parameter int DEPTH  = ALU_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  input  logic [OPW-1:0] cmd_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_opcode,
  input  logic [W-1:0]   alu_x,
  input  logic [W-1:0]   alu_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_x,
  output logic [W-1:0]   rsp_y,
  output logic [OPW-1:0] rsp_op,
  output logic           busy,
  output logic [7:0]     tx_count,
  output alu_state_e     dbg_state
);

  localparam int DW    = 2*W + OPW;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  if (SETTLE < 1) begin : g_bad_settle
    $error("alu_issue_ctrl: SETTLE must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("alu_issue_ctrl: DEPTH must be a power of two and at least 2");
  end

  alu_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]   alu_a_q, alu_b_q, rsp_x_q, rsp_y_q;
  logic [OPW-1:0] alu_op_q, rsp_op_q;
  logic           rsp_valid_q;
  logic [7:0]     tx_count_q;

  logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DW-1:0]  fifo_head;
  logic [W-1:0]   head_a, head_b;
  logic [OPW-1:0] head_op;

  // cmd_ready depends only on occupancy, never on a same-cycle pop.
  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & ~fifo_full;

  // Pop from IDLE, or straight out of RESP on the response handshake so the
  // next command issues without passing through IDLE.
  assign fifo_pop = ~fifo_empty &
                    ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));

  assign {head_a, head_b, head_op} = fifo_head;

  alu_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i ({cmd_a, cmd_b, cmd_op}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      tx_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            alu_a_q  <= head_a;
            alu_b_q  <= head_b;
            alu_op_q <= head_op;
            cnt_q    <= CNT_INIT;
            state_q  <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            rsp_x_q     <= alu_x;
            rsp_y_q     <= alu_y;
            rsp_op_q    <= alu_op_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            tx_count_q  <= tx_count_q + 8'd1;
            if (fifo_pop) begin
              alu_a_q  <= head_a;
              alu_b_q  <= head_b;
              alu_op_q <= head_op;
              cnt_q    <= CNT_INIT;
              state_q  <= DRIVE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_op     = rsp_op_q;
  assign tx_count   = tx_count_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU (x = a+b mod 16, y = a&b).
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
  logic [3:0] alu_a, alu_b, alu_opcode, alu_x, alu_y;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_x, rsp_y, rsp_op;
  logic       busy;
  logic [7:0] tx_count;
  alu_state_e dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  int          exp_cyc_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Behavioural ALU driven by the DUT's registered operands.
  assign alu_x = alu_a + alu_b;
  assign alu_y = alu_a & alu_b;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_x      (rsp_x),
    .rsp_y      (rsp_y),
    .rsp_op     (rsp_op),
    .busy       (busy),
    .tx_count   (tx_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input alu_cmd_t c);
    cmd_a     = c.a;
    cmd_b     = c.b;
    cmd_op    = c.op;
    cmd_valid = 1'b1;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rsp_word();
    return 32'({rsp_x, rsp_y, rsp_op});
  endfunction

  // Directed command tables with hand-computed {x, y, op}.
  alu_cmd_t t3_cmd [5] = '{'{4'd1, 4'd2, 4'd3}, '{4'd5, 4'd6, 4'd7}, '{4'd9, 4'd3, 4'd1},
                           '{4'd15, 4'd1, 4'd2}, '{4'd8, 4'd8, 4'd4}};
  logic [11:0] t3_exp [5] = '{12'h303, 12'hB47, 12'hC11, 12'h012, 12'h084};
  alu_cmd_t t4_cmd [3] = '{'{4'd2, 4'd3, 4'd5}, '{4'd7, 4'd7, 4'd6}, '{4'd12, 4'd4, 4'd9}};
  logic [11:0] t4_exp [3] = '{12'h525, 12'hE76, 12'h049};

  initial begin
    alu_cmd_t   c;
    logic [3:0] sx, sy;
    logic       acc;
    int         pushed;
    int         seen;
    int         cyc;

    // ---- power-on reset ----
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outputs", 32'({rsp_valid, busy, alu_a, alu_b, alu_opcode, rsp_x, rsp_y, rsp_op}), 32'd0);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // ---- 1: reset asserted while a command is in DRIVE ----
    set_cmd('{4'd3, 4'd5, 4'd7});
    step();
    cmd_valid = 1'b0;
    step();
    chk("t1_state_drive", 32'(dbg_state), 32'(DRIVE));
    chk("t1_alu_loaded", 32'({alu_a, alu_b, alu_opcode}), 32'h357);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_outputs", 32'({rsp_valid, busy, alu_a, alu_b, alu_opcode, rsp_x, rsp_y, rsp_op}), 32'd0);
    chk("t1_async_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t1_no_rsp", 32'({rsp_valid, busy}), 32'd0);
    end
    chk("t1_tx_count", 32'(tx_count), 32'd0);

    // ---- 2 + 5: single command, latency, then response held 5 cycles ----
    set_cmd('{4'b1100, 4'b0010, 4'b1010});
    step();                                   // accept edge E0
    cmd_valid = 1'b0;
    chk("t2_e0_rsp_valid", 32'(rsp_valid), 32'd0);
    step();                                   // E1: operands issued
    chk("t2_e1_alu", 32'({alu_a, alu_b, alu_opcode}), 32'hC2A);
    chk("t2_e1_rsp_valid", 32'(rsp_valid), 32'd0);
    step();                                   // E2
    chk("t2_e2_rsp_valid", 32'(rsp_valid), 32'd0);
    step();                                   // E3: response captured
    chk("t2_e3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_e3_rsp", rsp_word(), 32'hE0A);
    chk("t2_e3_state", 32'(dbg_state), 32'(RESP));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_hold_rsp", 32'({rsp_valid, rsp_x, rsp_y, rsp_op}), 32'h1E0A);
      chk("t5_hold_alu", 32'({alu_a, alu_b, alu_opcode}), 32'hC2A);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t2_after_hs_valid", 32'(rsp_valid), 32'd0);
    chk("t2_tx_count", 32'(tx_count), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_alu_hold_idle", 32'({alu_a, alu_b, alu_opcode}), 32'hC2A);

    // ---- 3: capacity with rsp_ready low ----
    for (int i = 0; i < 5; i++) begin
      set_cmd(t3_cmd[i]);
      chk("t3_ready_accept", 32'(cmd_ready), 32'd1);
      exp_q.push_back(t3_exp[i]);
      step();
    end
    set_cmd('{4'd4, 4'd4, 4'd4});
    chk("t3_ready_stall", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_ready_stall_hold", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    chk("t3_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      if (rsp_valid) chk("t3_resp_order", rsp_word(), 32'(exp_q.pop_front()));
      if (exp_q.size() > 0) step();
    end
    chk("t3_drain_left", 32'(exp_q.size()), 32'd0);
    step();
    chk("t3_tx_count", 32'(tx_count), 32'd6);
    chk("t3_busy_drained", 32'(busy), 32'd0);

    // ---- 4: three back-to-back commands, rsp_ready high ----
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(t4_exp[i]);
      exp_cyc_q.push_back(3 * (i + 1));
    end
    set_cmd(t4_cmd[0]);
    step();                                   // accept edge, cycle 0
    cyc = 0;
    for (int k = 1; k < 30 && exp_q.size() > 0; k++) begin
      if (k < 3) set_cmd(t4_cmd[k]);
      else cmd_valid = 1'b0;
      step();
      cyc = k;
      if (rsp_valid) begin
        chk("t4_resp_data", rsp_word(), 32'(exp_q.pop_front()));
        chk("t4_resp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
    cmd_valid = 1'b0;
    chk("t4_drain_left", 32'(exp_q.size()), 32'd0);
    step();
    chk("t4_tx_count", 32'(tx_count), 32'd9);

    // ---- 6: 247 more transactions wrap tx_count to 0 ----
    pushed = 0;
    seen   = 0;
    c.a  = 4'($urandom_range(0, 15));
    c.b  = 4'($urandom_range(0, 15));
    c.op = 4'($urandom_range(0, 15));
    set_cmd(c);
    for (int k = 0; k < 3000 && seen < 247; k++) begin
      acc = cmd_valid && cmd_ready;
      if (acc) begin
        sx = cmd_a + cmd_b;
        sy = cmd_a & cmd_b;
        exp_q.push_back({sx, sy, cmd_op});
      end
      step();
      if (acc) begin
        pushed++;
        if (pushed < 247) begin
          c.a  = 4'($urandom_range(0, 15));
          c.b  = 4'($urandom_range(0, 15));
          c.op = 4'($urandom_range(0, 15));
          set_cmd(c);
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() > 0) chk("t6_resp", rsp_word(), 32'(exp_q.pop_front()));
        else chk("t6_unexpected_rsp", 32'(rsp_valid), 32'd0);
        seen++;
      end
    end
    chk("t6_seen", 32'(seen), 32'd247);
    step();
    chk("t6_tx_wrap", 32'(tx_count), 32'd0);
    chk("t6_busy_drained", 32'(busy), 32'd0);
    chk("t6_rsp_valid_low", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;

    // ---- final report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
